// File: rtl/racetrack_shift_ctrl_pkg.sv
// Shared definitions for the racetrack shift-port controller: FSM state
// encoding and the default pulse/gap timing also used by the LiM FSM.
package racetrack_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } shift_state_e;

  localparam int SHIFT_PULSE_CYCLES = 2;
  localparam int SHIFT_GAP_CYCLES   = 1;

  // Width of the pulse/gap timer; comfortably covers any practical setting.
  localparam int SHIFT_TIMER_WIDTH  = 8;

endpackage

// File: rtl/racetrack_shift_ctrl_pulse_timer.sv
// Loadable down-counter used to time the high (PULSE) and low (GAP)
// portions of each shift pulse. Counts down to zero and parks there.
module racetrack_pulse_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt;

  // Load takes priority; otherwise decrement until zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/racetrack_shift_ctrl.sv
// Shift-port controller between the LiM memory control FSM and the
// racetrack array. Turns the set/reset phase enables into a train of
// timed shift pulses, tracks the head offset, and reports completion.
//
// Handshake: an enable (shift_en_s_i or shift_en_r_i) is a level request
// that the FSM holds until it sees the matching done; done stays high
// until the owning enable drops, and dropping the enable early aborts
// the shift (a partially driven pulse does not count toward track_pos_o).
module racetrack_shift_ctrl
  import racetrack_shift_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 10,
  parameter int POS_LSB      = 2,
  parameter int PULSE_CYCLES = SHIFT_PULSE_CYCLES,
  parameter int GAP_CYCLES   = SHIFT_GAP_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  shift_en_s_i,
  input  logic                  shift_en_r_i,
  input  logic                  source_shift_sel_i,
  output logic                  shift_pulse_o,
  output logic                  shift_dir_o,
  output logic                  shift_done_s_o,
  output logic                  shift_done_r_o,
  output logic [CNT_WIDTH-1:0]  track_pos_o,
  output logic                  busy_o
);

  localparam logic [SHIFT_TIMER_WIDTH-1:0] PULSE_LOAD =
    SHIFT_TIMER_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [SHIFT_TIMER_WIDTH-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? SHIFT_TIMER_WIDTH'(GAP_CYCLES - 1) : '0;

  shift_state_e                 state;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         pos;
  logic                         owner_en;
  logic                         timer_load;
  logic [SHIFT_TIMER_WIDTH-1:0] timer_load_val;
  logic                         timer_zero;
  logic                         unused_addr;

  assign pos         = addr_i[POS_LSB +: CNT_WIDTH];
  assign unused_addr = ^addr_i;

  // The phase that started the shift owns it; the other enable is ignored.
  assign owner_en = shift_dir_o ? shift_en_s_i : shift_en_r_i;

  // Reload the timer on entry to PULSE and at the end of each PULSE/GAP.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = PULSE_LOAD;
    case (state)
      LOAD:  timer_load = 1'b1;
      PULSE: begin
        timer_load     = timer_zero;
        timer_load_val = (GAP_CYCLES > 0) ? GAP_LOAD : PULSE_LOAD;
      end
      GAP:   timer_load = timer_zero;
      default: ;
    endcase
  end

  racetrack_pulse_timer #(
    .WIDTH (SHIFT_TIMER_WIDTH)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .zero_o     (timer_zero)
  );

  // Main FSM with shift counter, track position and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      track_pos_o    <= '0;
      shift_pulse_o  <= 1'b0;
      shift_dir_o    <= 1'b1;
      shift_done_s_o <= 1'b0;
      shift_done_r_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (shift_en_s_i) begin
            state       <= LOAD;
            cnt         <= pos;
            shift_dir_o <= 1'b1;
            busy_o      <= 1'b1;
          end else if (shift_en_r_i) begin
            state       <= LOAD;
            cnt         <= source_shift_sel_i ? track_pos_o : pos;
            shift_dir_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        LOAD: begin
          if (!owner_en) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == '0) begin
            state          <= DONE;
            shift_done_s_o <= shift_dir_o;
            shift_done_r_o <= !shift_dir_o;
          end else begin
            state         <= PULSE;
            shift_pulse_o <= 1'b1;
          end
        end
        PULSE: begin
          if (!owner_en) begin
            state         <= IDLE;
            shift_pulse_o <= 1'b0;
            busy_o        <= 1'b0;
          end else if (timer_zero) begin
            cnt         <= cnt - CNT_WIDTH'(1);
            track_pos_o <= shift_dir_o ? track_pos_o + CNT_WIDTH'(1)
                                       : track_pos_o - CNT_WIDTH'(1);
            if (cnt == CNT_WIDTH'(1)) begin
              state          <= DONE;
              shift_pulse_o  <= 1'b0;
              shift_done_s_o <= shift_dir_o;
              shift_done_r_o <= !shift_dir_o;
            end else if (GAP_CYCLES == 0) begin
              state <= PULSE;
            end else begin
              state         <= GAP;
              shift_pulse_o <= 1'b0;
            end
          end
        end
        GAP: begin
          if (!owner_en) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (timer_zero) begin
            state         <= PULSE;
            shift_pulse_o <= 1'b1;
          end
        end
        DONE: begin
          if (!owner_en) begin
            state          <= IDLE;
            shift_done_s_o <= 1'b0;
            shift_done_r_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          shift_pulse_o  <= 1'b0;
          shift_done_s_o <= 1'b0;
          shift_done_r_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_racetrack_shift_ctrl.sv
// Directed bench for racetrack_shift_ctrl: set/reset phases, aborts,
// simultaneous enables, reset during a pulse, and a zero-gap variant.
module tb_racetrack_shift_ctrl;

  localparam int P = 2;
  localparam int G = 1;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        en_s;
  logic        en_r;
  logic        sel;
  logic        pulse;
  logic        dir;
  logic        done_s;
  logic        done_r;
  logic [9:0]  track;
  logic        busy;

  logic [31:0] g0_addr;
  logic        g0_en_s;
  logic        g0_en_r;
  logic        g0_sel;
  logic        g0_pulse;
  logic        g0_dir;
  logic        g0_done_s;
  logic        g0_done_r;
  logic [9:0]  g0_track;
  logic        g0_busy;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  racetrack_shift_ctrl #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .addr_i             (addr),
    .shift_en_s_i       (en_s),
    .shift_en_r_i       (en_r),
    .source_shift_sel_i (sel),
    .shift_pulse_o      (pulse),
    .shift_dir_o        (dir),
    .shift_done_s_o     (done_s),
    .shift_done_r_o     (done_r),
    .track_pos_o        (track),
    .busy_o             (busy)
  );

  racetrack_shift_ctrl #(
    .PULSE_CYCLES (2),
    .GAP_CYCLES   (0)
  ) dut_g0 (
    .clk_i              (clk),
    .rst_i              (rst),
    .addr_i             (g0_addr),
    .shift_en_s_i       (g0_en_s),
    .shift_en_r_i       (g0_en_r),
    .source_shift_sel_i (g0_sel),
    .shift_pulse_o      (g0_pulse),
    .shift_dir_o        (g0_dir),
    .shift_done_s_o     (g0_done_s),
    .shift_done_r_o     (g0_done_r),
    .track_pos_o        (g0_track),
    .busy_o             (g0_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int latency(input int k, input int pc, input int gc);
    return (k == 0) ? 2 : 2 + k * pc + (k - 1) * gc;
  endfunction

  // Drive one phase request, observe until done, compare against the queue.
  task automatic run_phase(input string tag, input logic s, input logic r,
                           input logic [31:0] a, input logic sv,
                           input int k, input int exp_track);
    int   rises;
    int   highs;
    int   done_at;
    logic prev;
    logic is_set;
    is_set = s;
    exp_q.push_back(32'(latency(k, P, G)));
    exp_q.push_back(32'(k));
    exp_q.push_back(32'(k * P));
    exp_q.push_back(32'(is_set));
    exp_q.push_back(32'(is_set));
    exp_q.push_back(32'(!is_set));
    exp_q.push_back(32'(exp_track));
    addr = a; en_s = s; en_r = r; sel = sv;
    rises = 0; highs = 0; done_at = -1; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (pulse && !prev) rises++;
      if (pulse) highs++;
      prev = pulse;
      if (done_s || done_r) begin
        done_at = c;
        break;
      end
    end
    check({tag, "_done_cycle"}, 32'(done_at), exp_q.pop_front());
    check({tag, "_pulses"}, 32'(rises), exp_q.pop_front());
    check({tag, "_pulse_high"}, 32'(highs), exp_q.pop_front());
    check({tag, "_dir"}, 32'(dir), exp_q.pop_front());
    check({tag, "_done_s"}, 32'(done_s), exp_q.pop_front());
    check({tag, "_done_r"}, 32'(done_r), exp_q.pop_front());
    check({tag, "_track"}, 32'(track), exp_q.pop_front());
    en_s = 1'b0; en_r = 1'b0;
    step();
    check({tag, "_release_busy"}, 32'(busy), 32'd0);
    check({tag, "_release_done"}, 32'({done_s, done_r}), 32'd0);
  endtask

  initial begin
    int k;
    int done_at;
    int rises;
    int highs;
    logic prev;
    vectors = 0; miscompares = 0;
    rst = 1'b1; addr = '0; en_s = 1'b0; en_r = 1'b0; sel = 1'b0;
    g0_addr = '0; g0_en_s = 1'b0; g0_en_r = 1'b0; g0_sel = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_done", 32'({done_s, done_r}), 32'd0);
    check("rst_track", 32'(track), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Zero-distance set, then a 3-step set and its return
    run_phase("set0", 1'b1, 1'b0, 32'h0, 1'b0, 0, 0);
    run_phase("set3", 1'b1, 1'b0, 32'hC, 1'b0, 3, 3);
    run_phase("ret3", 1'b0, 1'b1, 32'h0, 1'b1, 3, 0);
    check("idle_dir_hold", 32'(dir), 32'd0);

    // Abort a pos=5 set after two full pulses (drop enable during the gap)
    addr = 32'h14; en_s = 1'b1;
    repeat (7) step();
    check("abort_in_gap", 32'({busy, pulse}), 32'b10);
    en_s = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulse", 32'(pulse), 32'd0);
    check("abort_track", 32'(track), 32'd2);
    step();
    run_phase("ret_abort", 1'b0, 1'b1, 32'h0, 1'b1, 2, 0);

    // Both enables together: set phase wins; then return using addr pos
    run_phase("both", 1'b1, 1'b1, 32'h4, 1'b0, 1, 1);
    run_phase("ret_addr", 1'b0, 1'b1, 32'h4, 1'b0, 1, 0);

    // Random distance set and tracked return
    k = $urandom_range(1, 4);
    run_phase("rnd_set", 1'b1, 1'b0, 32'(k) << 2, 1'b0, k, k);
    run_phase("rnd_ret", 1'b0, 1'b1, 32'h0, 1'b1, k, 0);

    // Reset asserted while pulsing (after one completed pulse)
    addr = 32'hC; en_s = 1'b1;
    repeat (5) step();
    check("pre_rst_pulse", 32'(pulse), 32'd1);
    check("pre_rst_track", 32'(track), 32'd1);
    rst = 1'b1;
    step();
    check("midrst_pulse", 32'(pulse), 32'd0);
    check("midrst_done", 32'({done_s, done_r}), 32'd0);
    check("midrst_track", 32'(track), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dir", 32'(dir), 32'd1);
    rst = 1'b0; en_s = 1'b0;
    step();

    // Zero-gap instance: pos=2 gives one continuous 4-clock pulse
    exp_q.push_back(32'(latency(2, 2, 0)));
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd2);
    g0_addr = 32'h8; g0_en_s = 1'b1;
    rises = 0; highs = 0; done_at = -1; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (g0_pulse && !prev) rises++;
      if (g0_pulse) highs++;
      prev = g0_pulse;
      if (g0_done_s) begin
        done_at = c;
        break;
      end
    end
    check("g0_done_cycle", 32'(done_at), exp_q.pop_front());
    check("g0_pulses", 32'(rises), exp_q.pop_front());
    check("g0_pulse_high", 32'(highs), exp_q.pop_front());
    check("g0_track", 32'(g0_track), exp_q.pop_front());
    g0_en_s = 1'b0;
    step();
    check("g0_release_busy", 32'(g0_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
